// File: rtl/pio_tctrl_mdev_pkg.sv
// pio_tctrl_mdev_pkg: shared PIO cycle state encoding and mode-0 default timings at 100 MHz.
package pio_tctrl_mdev_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITRDY, RECOV} pio_state_t;
   localparam int MODE0_T1   = 6;
   localparam int MODE0_T2   = 28;
   localparam int MODE0_T4   = 2;
   localparam int MODE0_TEOC = 23;
endpackage

// File: rtl/pio_tctrl_mdev_dcnt.sv
// pio_tctrl_mdev_dcnt: loadable down counter; done while count is 1, or 0 after a zero load.
module pio_tctrl_mdev_dcnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nReset,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] val,
   output logic         done
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge nReset)
      if (!nReset) cnt <= '0;
      else if (rst) cnt <= '0;
      else if (load) cnt <= val;
      else if (en && cnt > W'(1)) cnt <= cnt - W'(1);

   assign done = cnt <= W'(1);
endmodule

// File: rtl/pio_tctrl_mdev.sv
// pio_tctrl_mdev: PIO cycle sequencer with per-device timing sets, IORDY sync/timeout
// and a one-deep request queue.
module pio_tctrl_mdev
   import pio_tctrl_mdev_pkg::*;
#(
   parameter int TWIDTH  = 8,
   parameter int NDEV    = 2,
   parameter int DSW     = 1,
   parameter int TOWIDTH = 12
) (
   input  logic                   clk,
   input  logic                   nReset,
   input  logic                   rst,
   input  logic [NDEV-1:0]        IORDY_en,
   input  logic [NDEV*TWIDTH-1:0] T1,
   input  logic [NDEV*TWIDTH-1:0] T2,
   input  logic [NDEV*TWIDTH-1:0] T4,
   input  logic [NDEV*TWIDTH-1:0] Teoc,
   input  logic [TOWIDTH-1:0]     TO,
   input  logic                   go,
   input  logic                   we,
   input  logic [DSW-1:0]         dev_sel,
   output logic                   busy,
   output logic                   oe,
   output logic                   DIOR,
   output logic                   DIOW,
   output logic                   dstrb,
   output logic                   done,
   output logic                   err,
   input  logic                   IORDY
);
   pio_state_t state, nstate;
   logic q_v, q_we, src_we, start, to_hit, enter_rc, strobe;
   logic sync1, rdy_s, we_l, en_l, tmo, h_seen;
   logic ph_done, h_done, r_done, to_done;
   logic [DSW-1:0] q_dev, src_dev;
   logic [TWIDTH-1:0] t2_l, t4_l, teoc_l;
   logic [TOWIDTH-1:0] to_l;
   int sel;

   // A pending request always wins over a fresh go arriving in IDLE.
   assign start    = state == IDLE && (q_v || go);
   assign src_we   = q_v ? q_we : we;
   assign src_dev  = q_v ? q_dev : dev_sel;
   assign sel      = int'(src_dev) < NDEV ? int'(src_dev) : 0;
   assign enter_rc = state != RECOV && nstate == RECOV;

   always_ff @(posedge clk or negedge nReset)
      if (!nReset) state <= IDLE;
      else state <= rst ? IDLE : nstate;

   always_comb begin
      nstate = state;
      to_hit = 1'b0;
      case (state)
         IDLE:    nstate = start ? SETUP : IDLE;
         SETUP:   nstate = ph_done ? STROBE : SETUP;
         STROBE:  nstate = !ph_done ? STROBE : (!en_l || rdy_s) ? RECOV : WAITRDY;
         WAITRDY: begin
            to_hit = !rdy_s && to_l != '0 && to_done;
            nstate = (rdy_s || to_hit) ? RECOV : WAITRDY;
         end
         RECOV:   nstate = (h_done && r_done) ? IDLE : RECOV;
         default: nstate = IDLE;
      endcase
   end

   assign strobe = state == STROBE || state == WAITRDY;
   assign DIOR   = strobe && !we_l;
   assign DIOW   = strobe && we_l;
   assign oe     = we_l && (state inside {SETUP, STROBE, WAITRDY} || (state == RECOV && !h_done));
   assign done   = state == RECOV && h_done && !h_seen;
   assign err    = done && tmo;
   assign busy   = state != IDLE || q_v;

   pio_tctrl_mdev_dcnt #(.W(TWIDTH)) u_ph (
      .clk, .nReset, .rst, .load(start || (state == SETUP && ph_done)), .en(1'b1),
      .val(state == IDLE ? T1[sel*TWIDTH +: TWIDTH] : t2_l), .done(ph_done));
   pio_tctrl_mdev_dcnt #(.W(TWIDTH)) u_hold (
      .clk, .nReset, .rst, .load(enter_rc), .en(1'b1), .val(t4_l), .done(h_done));
   pio_tctrl_mdev_dcnt #(.W(TWIDTH)) u_recov (
      .clk, .nReset, .rst, .load(enter_rc), .en(1'b1), .val(teoc_l), .done(r_done));
   pio_tctrl_mdev_dcnt #(.W(TOWIDTH)) u_tmo (
      .clk, .nReset, .rst, .load(state == STROBE && nstate == WAITRDY), .en(1'b1),
      .val(to_l), .done(to_done));

   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         {sync1, rdy_s, dstrb, h_seen, tmo, q_v, q_we} <= '0;
         q_dev <= '0;
      end else if (rst) begin
         {sync1, rdy_s, dstrb, h_seen, tmo, q_v, q_we} <= '0;
         q_dev <= '0;
      end else begin
         sync1  <= IORDY;
         rdy_s  <= sync1;
         dstrb  <= strobe && nstate == RECOV && !we_l && !to_hit;
         h_seen <= state == RECOV && (h_seen || h_done);
         if (start) tmo <= 1'b0;
         else if (to_hit) tmo <= 1'b1;
         if (start && q_v) q_v <= 1'b0;
         else if (go && state != IDLE && !q_v) begin
            q_v   <= 1'b1;
            q_we  <= we;
            q_dev <= dev_sel;
         end
      end

   // Per-cycle timing snapshot; only meaningful outside IDLE, so no sync clear.
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         {we_l, en_l} <= '0;
         {t2_l, t4_l, teoc_l} <= '0;
         to_l <= '0;
      end else if (start) begin
         we_l   <= src_we;
         en_l   <= IORDY_en[sel];
         t2_l   <= T2[sel*TWIDTH +: TWIDTH];
         t4_l   <= T4[sel*TWIDTH +: TWIDTH];
         teoc_l <= Teoc[sel*TWIDTH +: TWIDTH];
         to_l   <= TO;
      end
endmodule

// File: tb/tb_pio_tctrl_mdev.sv
// tb_pio_tctrl_mdev: table and random PIO cycles checked per clock against an
// event-time model, plus queue and reset sequences.
module tb_pio_tctrl_mdev;
   localparam int TW = 8, ND = 2, DW = 1, TOW = 12;
   localparam int M1 = pio_tctrl_mdev_pkg::MODE0_T1, M2 = pio_tctrl_mdev_pkg::MODE0_T2;
   localparam int M4 = pio_tctrl_mdev_pkg::MODE0_T4, ME = pio_tctrl_mdev_pkg::MODE0_TEOC;

   logic clk = 0, nReset = 0, rst = 0, go = 0, we = 0, IORDY = 0;
   logic [ND-1:0] IORDY_en = '0;
   logic [ND*TW-1:0] T1 = '0, T2 = '0, T4 = '0, Teoc = '0;
   logic [TOW-1:0] TO = '0;
   logic [DW-1:0] dev_sel = '0;
   logic busy, oe, DIOR, DIOW, dstrb, done, err;
   logic [6:0] outv;
   int total = 0, bad = 0;

   typedef struct {
      logic we; int dev, t1, t2, t4, teoc; logic en; int to, rel;
      int on, fall, dn, idle; logic err;
   } vec_t;
   vec_t tbl[10];

   pio_tctrl_mdev #(.TWIDTH(TW), .NDEV(ND), .DSW(DW), .TOWIDTH(TOW)) dut (
      .clk(clk), .nReset(nReset), .rst(rst), .IORDY_en(IORDY_en), .T1(T1), .T2(T2),
      .T4(T4), .Teoc(Teoc), .TO(TO), .go(go), .we(we), .dev_sel(dev_sel), .busy(busy),
      .oe(oe), .DIOR(DIOR), .DIOW(DIOW), .dstrb(dstrb), .done(done), .err(err), .IORDY(IORDY));

   assign outv = {busy, oe, DIOR, DIOW, dstrb, done, err};
   always #5 clk = ~clk;

   function automatic int c1(int v);
      return v == 0 ? 1 : v;
   endfunction

   // Event times relative to the go cycle (0); IORDY high from cycle rel, seen 2 clks later.
   function automatic vec_t model(vec_t v);
      vec_t r;
      int l, s;
      r = v;
      l = c1(v.t1) + c1(v.t2);
      s = v.rel + 2;
      r.err = 1'b0;
      r.on = c1(v.t1) + 1;
      if (!v.en || s <= l) r.fall = l + 1;
      else if (v.to != 0 && l + v.to < s) begin
         r.fall = l + v.to + 1;
         r.err = 1'b1;
      end else r.fall = s + 1;
      r.dn = r.fall + c1(v.t4) - 1;
      r.idle = r.fall + (c1(v.t4) > c1(v.teoc) ? c1(v.t4) : c1(v.teoc));
      return r;
   endfunction

   function automatic logic [6:0] expv(vec_t v, int k);
      logic s;
      s = k >= v.on && k < v.fall;
      return {k >= 1 && k < v.idle, v.we && k >= 1 && k < v.dn, s && !v.we, s && v.we,
              !v.we && !v.err && k == v.fall, k == v.dn, v.err && k == v.dn};
   endfunction

   task automatic chk(string nm, int k, logic [6:0] got, logic [6:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d {busy,oe,DIOR,DIOW,dstrb,done,err} got=%b exp=%b", nm, k, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      T1 = (ND*TW)'($urandom); T2 = (ND*TW)'($urandom);
      T4 = (ND*TW)'($urandom); Teoc = (ND*TW)'($urandom);
      IORDY_en = ND'($urandom); TO = TOW'($urandom);
      we = 1'($urandom); dev_sel = DW'($urandom);
   endtask

   task automatic drive(vec_t v);
      scramble();
      T1[v.dev*TW +: TW] = TW'(v.t1);
      T2[v.dev*TW +: TW] = TW'(v.t2);
      T4[v.dev*TW +: TW] = TW'(v.t4);
      Teoc[v.dev*TW +: TW] = TW'(v.teoc);
      IORDY_en = {ND{~v.en}};
      IORDY_en[v.dev] = v.en;
      TO = TOW'(v.to);
      we = v.we;
      dev_sel = DW'(v.dev);
   endtask

   task automatic run_vec(string nm, vec_t v);
      drive(v);
      go = 1'b1;
      IORDY = v.rel <= 0;
      for (int k = 0; k <= v.idle; k++) begin
         @(negedge clk);
         chk(nm, k, outv, expv(v, k));
         step();
         go = 1'b0;
         if (k == 0) scramble();
         IORDY = k + 1 >= v.rel;
      end
   endtask

   initial begin
      vec_t a, b, c, v;
      //          we   dev t1  t2  t4  teoc en  to  rel   on  fall dn   idle err
      tbl[0] = '{1'b0, 0, M1, M2, M4, ME, 1'b0, 0, 0,    7,  35,  36,  58, 1'b0};
      tbl[1] = '{1'b1, 1, 2,  5,  4,  3,  1'b0, 0, 0,    3,  8,   11,  12, 1'b0};
      tbl[2] = '{1'b0, 0, M1, M2, M4, ME, 1'b1, 0, 44,   7,  47,  48,  70, 1'b0};
      tbl[3] = '{1'b0, 0, M1, M2, M4, ME, 1'b1, 50, 1000, 7, 85,  86,  108, 1'b1};
      tbl[4] = '{1'b1, 1, 0,  0,  0,  0,  1'b0, 0, 0,    2,  3,   3,   4,  1'b0};
      tbl[5] = '{1'b0, 0, 2,  3,  1,  2,  1'b1, 0, 100,  3,  103, 103, 105, 1'b0};
      tbl[6] = '{1'b0, 1, 3,  4,  3,  5,  1'b1, 7, 0,    4,  8,   10,  13, 1'b0};
      tbl[7] = '{1'b1, 0, 1,  1,  1,  1,  1'b1, 5, 5,    2,  8,   8,   9,  1'b0};
      tbl[8] = '{1'b0, 1, 1,  1,  1,  1,  1'b1, 5, 6,    2,  8,   8,   9,  1'b1};
      tbl[9] = '{1'b0, 1, 2,  2,  2,  2,  1'b0, 3, 1000, 3,  5,   6,   7,  1'b0};

      go = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("reset_hold", k, outv, 7'b0);
      end
      step();
      go = 1'b0;
      nReset = 1'b1;
      step();

      for (int i = 0; i < 10; i++) run_vec($sformatf("table%0d", i), tbl[i]);

      for (int i = 0; i < 40; i++) begin
         v.we = 1'($urandom_range(0, 1));
         v.dev = int'($urandom_range(0, ND - 1));
         v.t1 = int'($urandom_range(0, 12)); v.t2 = int'($urandom_range(0, 12));
         v.t4 = int'($urandom_range(0, 12)); v.teoc = int'($urandom_range(0, 12));
         v.en = 1'($urandom_range(0, 1));
         v.to = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 15));
         v.rel = $urandom_range(0, 3) == 0 ? 200 : int'($urandom_range(0, 30));
         run_vec($sformatf("rand%0d", i), model(v));
      end

      // Queue: second go queued mid-cycle, third go dropped while queue is full.
      a = model('{1'b0, 0, 2, 3, 2, 3, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0});
      b = model('{1'b1, 1, 1, 2, 1, 1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0});
      T1 = {8'd1, 8'd2}; T2 = {8'd2, 8'd3}; T4 = {8'd1, 8'd2}; Teoc = {8'd1, 8'd3};
      IORDY_en = '0; TO = '0;
      for (int k = 0; k <= 40; k++) begin
         go = k == 0 || k == 3 || k == 5;
         we = k == 3;
         dev_sel = DW'(k == 3);
         @(negedge clk);
         chk("queue", k, outv, k < 9 ? expv(a, k) : k == 9 ? 7'b1000000 : expv(b, k - 9));
         step();
      end
      go = 1'b0;

      // Sync reset during WAITRDY with a request queued.
      c = model('{1'b0, 0, 2, 2, 2, 2, 1'b1, 0, 1000, 0, 0, 0, 0, 1'b0});
      T1 = {8'd9, 8'd2}; T2 = {8'd9, 8'd2}; T4 = {8'd9, 8'd2}; Teoc = {8'd9, 8'd2};
      IORDY_en = 2'b01; TO = '0; IORDY = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         go = k == 0 || k == 3;
         we = 1'b0;
         dev_sel = '0;
         rst = k == 8;
         IORDY = k >= 12;
         @(negedge clk);
         chk("sync_rst", k, outv, k <= 8 ? expv(c, k) : 7'b0);
         step();
      end
      go = 1'b0;
      rst = 1'b0;

      // Async reset in the middle of a strobe.
      drive(tbl[0]);
      go = 1'b1;
      step();
      go = 1'b0;
      repeat (9) step();
      @(negedge clk);
      chk("pre_async", 10, outv, expv(tbl[0], 10));
      #2 nReset = 1'b0;
      #1 chk("async_rst", 10, outv, 7'b0);
      step();
      nReset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_async", k, outv, 7'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
